fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the PC datapath and the instruction-memory port of the RV32I core. Owns the architectural fetch PC and issues one request at a time to instruction memory. Presents fetched instructions to decode with a valid/stall handshake, and applies branch/jump/jalr redirects from execute, discarding any stale in-flight response.

---
 rtl/fetch_ctrl_if.sv | 43 ++++
 rtl/fetch_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the redirect, decode handshake and instruction-memory
// port signals of the fetch sequencer. The master modport is the fetch_ctrl
// view; the slave modport is the surrounding core/memory view.
interface fetch_ctrl_if;

  // Redirect from execute
  logic        redirect;
  logic [31:0] redirect_pc;

  // Decode handshake
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  // Instruction-memory port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Error status
  logic        misalign_err;

  modport master (
    input  redirect, redirect_pc, stall,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    output misalign_err
  );

  modport slave (
    output redirect, redirect_pc, stall,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    input  misalign_err
  );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I instruction-fetch sequencer. Owns the fetch PC, keeps at
// most one instruction-memory request outstanding, presents each fetched word
// to decode with a valid/stall handshake and applies execute redirects while
// discarding any stale in-flight response.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target enters a sticky ERR
//               state (no requests, misalign_err=1) left only by rst.
//   undefined : redirect targets are word-aligned by clearing bits [1:0];
//               misalign_err is tied low.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [2:0] {
    S_FETCH,  // request on the bus, waiting for grant
    S_WAIT,   // request granted, waiting for read data
    S_HOLD,   // instruction presented to decode
    S_DRAIN   // stale response still outstanding, to be dropped
`ifdef FETCH_MISALIGN_CHECK_EN
    , S_ERR   // misaligned redirect seen, parked until reset
`endif
  } state_e;

  state_e      state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic        if_valid_q,    if_valid_d;
  logic [31:0] if_instr_q,    if_instr_d;
  logic [31:0] if_pc_q,       if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;

  // Redirect target as it is loaded into pc, and whether it must trap instead.
  logic [31:0] redirect_tgt;
  logic        redirect_err;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = bus.redirect_pc;
  assign redirect_err = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
  // Without the check the low bits are simply dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
  assign redirect_err = 1'b0;
`endif

  // Next-state, next-pc and decode-register update for every FSM state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;

    case (state_q)
      S_FETCH: begin
        // A redirect wins over the grant; if the stale request was granted
        // anyway its response still has to be drained.
        if (bus.redirect) begin
          if (redirect_err) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            state_d = S_ERR;
`endif
          end else begin
            pc_d    = redirect_tgt;
            state_d = bus.imem_gnt ? S_DRAIN : S_FETCH;
          end
        end else if (bus.imem_gnt) begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.redirect) begin
          if (redirect_err) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            state_d = S_ERR;
`endif
          end else begin
            // Data arriving together with the redirect is stale: drop it.
            pc_d    = redirect_tgt;
            state_d = bus.imem_rvalid ? S_FETCH : S_DRAIN;
          end
        end else if (bus.imem_rvalid) begin
          if_instr_d    = bus.imem_rdata;
          if_pc_d       = fetch_pc_q;
          if_pc_plus4_d = fetch_pc_q + 32'd4;
          if_valid_d    = 1'b1;
          pc_d          = fetch_pc_q + 32'd4;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        // Redirect has priority over decode consuming the instruction.
        if (bus.redirect) begin
          if_valid_d = 1'b0;
          if (redirect_err) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            state_d = S_ERR;
`endif
          end else begin
            pc_d    = redirect_tgt;
            state_d = S_FETCH;
          end
        end else if (!bus.stall) begin
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect_err) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          state_d = S_ERR;
`endif
        end else begin
          if (bus.redirect) begin
            pc_d = redirect_tgt;
          end
          if (bus.imem_rvalid) begin
            state_d = S_FETCH;
          end
        end
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      S_ERR: begin
        // Sticky until reset; late responses are ignored.
        if_valid_d = 1'b0;
      end
`endif

      default: begin
        state_d = S_FETCH;
      end
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    // Nothing is presented to decode once the sequencer has trapped.
    if (state_d == S_ERR) begin
      if_valid_d = 1'b0;
    end
`endif
  end

  // State, PC and decode output registers; rst aborts any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_INSTR;
      if_pc_q       <= 32'h0000_0000;
      if_pc_plus4_q <= 32'h0000_0004;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed for this edge, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  // Memory request is decoded from the registered state only.
  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;

  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.misalign_err = (state_q == S_ERR);
`else
  assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. The stimulus block plays the
// role of instruction memory and execute, pushing the expected decode output
// whenever it returns a response that must be presented; a negedge monitor
// pops and compares on every rising if_valid.
module tb_fetch_ctrl;

  logic clk;
  logic rst;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: advance past the rising edge, then drive/sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},    {31'd0, bus.imem_req},     32'd1);
    check({tag, "_addr"},   bus.imem_addr,             32'h0000_0000);
    check({tag, "_valid"},  {31'd0, bus.if_valid},     32'd0);
    check({tag, "_instr"},  bus.if_instr,              32'h0000_0013);
    check({tag, "_pc"},     bus.if_pc,                 32'h0000_0000);
    check({tag, "_pc4"},    bus.if_pc_plus4,           32'h0000_0004);
    check({tag, "_merr"},   {31'd0, bus.misalign_err}, 32'd0);
  endtask

  // Scoreboard monitor: each new presentation must match the oldest expectation.
  logic prev_valid;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.if_valid && !prev_valid) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected_valid: observed if_pc %h expected no presentation", bus.if_pc);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_if_pc",    bus.if_pc,       e.pc);
          check("sb_if_instr", bus.if_instr,    e.instr);
          check("sb_if_pc4",   bus.if_pc_plus4, e.pc + 32'd4);
        end
      end
      prev_valid <= bus.if_valid;
    end
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall       = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Best case: gnt in cycle 0, rvalid in cycle 1, present in 2, next req in 3.
    check("c0_req",  {31'd0, bus.imem_req}, 32'd1);
    check("c0_addr", bus.imem_addr,         32'h0);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("c1_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0010_0093;
    sb.push_back('{pc: 32'h0, instr: 32'h0010_0093});
    tick();
    bus.imem_rvalid = 1'b0;
    check("c2_valid", {31'd0, bus.if_valid}, 32'd1);
    check("c2_req",   {31'd0, bus.imem_req}, 32'd0);
    tick();
    check("c3_req",  {31'd0, bus.imem_req}, 32'd1);
    check("c3_addr", bus.imem_addr,         32'h4);

    // Stall held for 5 cycles in HOLD.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0020_8113;
    bus.stall       = 1'b1;
    sb.push_back('{pc: 32'h4, instr: 32'h0020_8113});
    tick();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req",   {31'd0, bus.imem_req}, 32'd0);
      check("stall_valid", {31'd0, bus.if_valid}, 32'd1);
      check("stall_pc",    bus.if_pc,             32'h4);
      check("stall_instr", bus.if_instr,          32'h0020_8113);
      tick();
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_req",   {31'd0, bus.imem_req}, 32'd1);
    check("unstall_addr",  bus.imem_addr,         32'h8);
    check("unstall_valid", {31'd0, bus.if_valid}, 32'd0);

    // Redirect in WAIT, stale data two cycles later is dropped.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick();
    bus.redirect = 1'b0;
    check("drain_req0", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check("drain_req1", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    check("drain_addr",  bus.imem_addr,         32'h100);
    check("drain_valid", {31'd0, bus.if_valid}, 32'd0);

    // Redirect and rvalid in the same WAIT cycle.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAAD_F00D;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.redirect    = 1'b0;
    check("same_req",   {31'd0, bus.imem_req}, 32'd1);
    check("same_addr",  bus.imem_addr,         32'h200);
    check("same_valid", {31'd0, bus.if_valid}, 32'd0);

    // Redirect during HOLD drops if_valid next cycle.
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0030_0193;
    bus.stall       = 1'b1;
    sb.push_back('{pc: 32'h200, instr: 32'h0030_0193});
    tick();
    bus.imem_rvalid = 1'b0;
    check("hold_valid", {31'd0, bus.if_valid}, 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    tick();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    check("hredir_valid", {31'd0, bus.if_valid}, 32'd0);
    check("hredir_addr",  bus.imem_addr,         32'h300);

    // Redirect in FETCH without grant, then +4 wrap at the top of memory.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    check("wrap_req",  {31'd0, bus.imem_req}, 32'd1);
    check("wrap_addr", bus.imem_addr,         32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0040_0213;
    sb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h0040_0213});
    tick();
    bus.imem_rvalid = 1'b0;
    check("wrap_pc4", bus.if_pc_plus4, 32'h0);
    tick();
    check("wrap_next", bus.imem_addr, 32'h0);

    // Redirect with grant in FETCH: the granted response is drained.
    bus.imem_gnt    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    tick();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b0;
    check("fdrain_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    tick();
    bus.imem_rvalid = 1'b0;
    check("fdrain_addr", bus.imem_addr, 32'h400);

    // Misaligned redirect target.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    tick();
    bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      check("err_merr",  {31'd0, bus.misalign_err}, 32'd1);
      check("err_req",   {31'd0, bus.imem_req},     32'd0);
      check("err_valid", {31'd0, bus.if_valid},     32'd0);
      bus.imem_gnt    = i[0];
      bus.imem_rvalid = ~i[0];
      tick();
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
`else
    check("mis_addr", bus.imem_addr,             32'h100);
    check("mis_merr", {31'd0, bus.misalign_err}, 32'd0);
    check("mis_req",  {31'd0, bus.imem_req},     32'd1);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("mis_wait_req", {31'd0, bus.imem_req}, 32'd0);
`endif

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_addr", bus.imem_addr, 32'h0);

    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
